// File: rtl/prbs8_checker.sv
// prbs8_checker
//   Receive-side checker for the 8-bit XNOR LFSR pattern (taps 7 and 4,
//   shift left, new bit into the LSB). It seeds a local LFSR from the
//   incoming stream, confirms lock over LOCK_CONFIRM bits, and then counts
//   bit errors against a free-running local reference.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   bit_valid_i  bit_in_i is sampled on this cycle
//   bit_in_i     received stream bit
//   clr_err_i    synchronous clear of err_count_o (and bit_count_o when built)
//   locked_o     checker is in LOCKED
//   err_pulse_o  one-cycle strobe per counted error
//   err_count_o  saturating error count
//   bit_count_o  valid bits checked while LOCKED
//
// Build option
//   PRBS8_CHK_BITCNT_EN : builds the 32-bit bit counter. When it is not
//   defined, bit_count_o is tied to 0.
//
// state     | meaning
// S_HUNT    | filling r with 8 stream bits to seed the local LFSR
// S_CONFIRM | seeded; checking LOCK_CONFIRM consecutive predictions
// S_LOCKED  | free-running reference, counting errors and watching the window

module prbs8_checker #(
  parameter int LOCK_CONFIRM = 8,
  parameter int ERR_WIN      = 32,
  parameter int ERR_MAX      = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid_i,
  input  logic             bit_in_i,
  input  logic             clr_err_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [31:0]      bit_count_o
);

  localparam int CONF_W = (LOCK_CONFIRM > 1) ? $clog2(LOCK_CONFIRM) : 1;
  localparam int WIN_W  = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int WERR_W = (ERR_MAX > 0) ? $clog2(ERR_MAX + 1) : 1;
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(LOCK_CONFIRM - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(ERR_WIN - 1);
  localparam logic [WERR_W-1:0] ERR_LIMIT = WERR_W'(ERR_MAX);
  localparam bit                LOSS_EN   = (ERR_MAX > 0);

  typedef enum logic [1:0] {
    S_HUNT,
    S_CONFIRM,
    S_LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         r_q, r_d;
  logic [2:0]         fill_q, fill_d;
  logic [CONF_W-1:0]  conf_q, conf_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]  win_err_q, win_err_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic               locked_q, locked_d;

  logic               pred;
  logic               mismatch;
  logic [7:0]         shift_in;
  logic [WERR_W-1:0]  win_err_inc;

  assign pred        = ~(r_q[7] ^ r_q[4]);
  assign mismatch    = bit_in_i ^ pred;
  assign shift_in    = {r_q[6:0], bit_in_i};
  assign win_err_inc = win_err_q + WERR_W'(1);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_d      = fill_q;
    conf_d      = conf_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (bit_valid_i) begin
      case (state_q)
        S_HUNT: begin
          r_d = shift_in;
          if (fill_q == 3'd7) begin
            fill_d = 3'd0;
            // All-ones is the XNOR lock-up state; it can never be a valid seed.
            if (shift_in != 8'hFF) begin
              state_d = S_CONFIRM;
              conf_d  = '0;
            end
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end

        S_CONFIRM: begin
          r_d = shift_in;
          if (mismatch) begin
            state_d = S_HUNT;
            fill_d  = 3'd0;
          end else if (conf_q == CONF_LAST) begin
            state_d   = S_LOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            conf_d = conf_q + CONF_W'(1);
          end
        end

        S_LOCKED: begin
          // Shift the prediction, not the received bit, so a single flipped
          // bit does not corrupt the reference and cost further errors.
          r_d = {r_q[6:0], pred};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
          end
          // Loss of lock outranks the end-of-window reset on the same bit.
          if (LOSS_EN && mismatch && (win_err_inc == ERR_LIMIT)) begin
            state_d = S_HUNT;
            fill_d  = 3'd0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (mismatch) begin
              win_err_d = win_err_inc;
            end
          end
        end

        default: begin
          state_d = S_HUNT;
          fill_d  = 3'd0;
        end
      endcase
    end

    if (clr_err_i) begin
      err_count_d = '0;
    end

    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      r_q         <= 8'h00;
      fill_q      <= 3'd0;
      conf_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      conf_q      <= conf_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_count_q;

`ifdef PRBS8_CHK_BITCNT_EN
  logic [31:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (bit_valid_i && (state_q == S_LOCKED)) begin
      bit_count_d = bit_count_q + 32'd1;
    end
    if (clr_err_i) begin
      bit_count_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count_q <= 32'd0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count_o = bit_count_q;
`else
  assign bit_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker. Two instances share the stimulus: one
// with default parameters and one with CNT_W=4, ERR_MAX=0 for saturation.
module tb_prbs8_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s;
  logic [31:0] bit_count_s;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  gen = 8'h00;
  bit          gap_en = 1'b0;

  always #5 clk = ~clk;

  prbs8_checker dut (
    .clk(clk), .rst_n(rst_n), .bit_valid_i(bit_valid), .bit_in_i(bit_in),
    .clr_err_i(clr_err), .locked_o(locked), .err_pulse_o(err_pulse),
    .err_count_o(err_count), .bit_count_o(bit_count)
  );

  prbs8_checker #(.CNT_W(4), .ERR_MAX(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bit_valid_i(bit_valid), .bit_in_i(bit_in),
    .clr_err_i(clr_err), .locked_o(locked_s), .err_pulse_o(err_pulse_s),
    .err_count_o(err_count_s), .bit_count_o(bit_count_s)
  );

  // One valid bit per call, optionally preceded by random idle cycles.
  task automatic send(input logic b, input logic clr);
    int n;
    if (gap_en) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
        clr_err   = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    clr_err   = clr;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    clr_err   = 1'b0;
  endtask

  // Next generator bit, optionally inverted on the wire.
  task automatic send_gen(input logic flip, input logic clr);
    logic nb;
    nb  = ~(gen[7] ^ gen[4]);
    gen = {gen[6:0], nb};
    send(nb ^ flip, clr);
  endtask

  task automatic send_clean(input int n);
    repeat (n) send_gen(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    clr_err   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gen   = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (locked !== 1'b0)        begin bad++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    total++; if (err_pulse !== 1'b0)     begin bad++; $display("FAIL reset_pulse got=%0b exp=0", err_pulse); end
    total++; if (err_count !== 16'd0)    begin bad++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
    total++; if (bit_count !== 32'd0)    begin bad++; $display("FAIL reset_bitcnt got=%0d exp=0", bit_count); end
    total++; if (locked_s !== 1'b0)      begin bad++; $display("FAIL reset_locked_s got=%0b exp=0", locked_s); end
    total++; if (err_count_s !== 4'd0)   begin bad++; $display("FAIL reset_errcnt_s got=%0d exp=0", err_count_s); end
    do_reset();
  endtask

  // Generator from 0 emits 1,1,1,1,1,0,0,0 then 1,1,0: lock after bit 16.
  task automatic test_clean_lock(input string tag);
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      send_gen(1'b0, 1'b0);
      if (err_pulse) pulses++;
      if (i == 15) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL %s_early_lock got=%0b exp=0", tag, locked); end
      end
    end
    total++; if (locked !== 1'b1)     begin bad++; $display("FAIL %s_lock got=%0b exp=1", tag, locked); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL %s_errcnt got=%0d exp=0", tag, err_count); end
    total++; if (pulses != 0)         begin bad++; $display("FAIL %s_pulses got=%0d exp=0", tag, pulses); end
  endtask

  task automatic test_single_error();
    int pulses;
    logic [31:0] exp_bc;
    send_clean(5);
    send_gen(1'b1, 1'b0);
    total++; if (err_pulse !== 1'b1)  begin bad++; $display("FAIL single_pulse got=%0b exp=1", err_pulse); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL single_errcnt got=%0d exp=1", err_count); end
    total++; if (locked !== 1'b1)     begin bad++; $display("FAIL single_locked got=%0b exp=1", locked); end
    send_gen(1'b0, 1'b0);
    total++; if (err_pulse !== 1'b0)  begin bad++; $display("FAIL single_pulse_len got=%0b exp=0", err_pulse); end
    pulses = 0;
    repeat (39) begin
      send_gen(1'b0, 1'b0);
      if (err_pulse) pulses++;
    end
    total++; if (pulses != 0)         begin bad++; $display("FAIL single_followon got=%0d exp=0", pulses); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL single_errcnt_end got=%0d exp=1", err_count); end
    total++; if (locked !== 1'b1)     begin bad++; $display("FAIL single_locked_end got=%0b exp=1", locked); end
`ifdef PRBS8_CHK_BITCNT_EN
    exp_bc = 32'd46;
`else
    exp_bc = 32'd0;
`endif
    total++; if (bit_count !== exp_bc) begin bad++; $display("FAIL single_bitcnt got=%0d exp=%0d", bit_count, exp_bc); end
  endtask

  // Errors at locked-bit indices 2,5,8,11; then relock from the clean stream.
  task automatic test_loss_of_lock(input string tag);
    logic flip;
    do_reset();
    send_clean(16);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL %s_prelock got=%0b exp=1", tag, locked); end
    for (int idx = 0; idx < 12; idx++) begin
      flip = (idx == 2) || (idx == 5) || (idx == 8) || (idx == 11);
      send_gen(flip, 1'b0);
      if (flip) begin
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL %s_pulse%0d got=%0b exp=1", tag, idx, err_pulse); end
      end
      if (idx == 8) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL %s_third_err got=%0b exp=1", tag, locked); end
      end
    end
    total++; if (locked !== 1'b0)     begin bad++; $display("FAIL %s_lost got=%0b exp=0", tag, locked); end
    total++; if (err_count !== 16'd4) begin bad++; $display("FAIL %s_errcnt got=%0d exp=4", tag, err_count); end
    for (int i = 1; i <= 16; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 15) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL %s_relock_early got=%0b exp=0", tag, locked); end
      end
    end
    total++; if (locked !== 1'b1)     begin bad++; $display("FAIL %s_relock got=%0b exp=1", tag, locked); end
    total++; if (err_count !== 16'd4) begin bad++; $display("FAIL %s_errcnt_kept got=%0d exp=4", tag, err_count); end
  endtask

  task automatic test_window_boundary();
    // Three errors closing window 0 and one opening window 1: no loss.
    do_reset();
    send_clean(16);
    send_clean(29);
    repeat (4) send_gen(1'b1, 1'b0);
    total++; if (locked !== 1'b1)     begin bad++; $display("FAIL win_split_locked got=%0b exp=1", locked); end
    total++; if (err_count !== 16'd4) begin bad++; $display("FAIL win_split_errcnt got=%0d exp=4", err_count); end
    // Fourth error on the last bit of the window: loss of lock wins.
    do_reset();
    send_clean(16);
    send_clean(28);
    repeat (3) send_gen(1'b1, 1'b0);
    total++; if (locked !== 1'b1)     begin bad++; $display("FAIL win_last_pre got=%0b exp=1", locked); end
    send_gen(1'b1, 1'b0);
    total++; if (locked !== 1'b0)     begin bad++; $display("FAIL win_last_lost got=%0b exp=0", locked); end
    total++; if (err_count !== 16'd4) begin bad++; $display("FAIL win_last_errcnt got=%0d exp=4", err_count); end
  endtask

  task automatic test_lockup_seed();
    int highs;
    highs = 0;
    do_reset();
    repeat (24) begin
      send(1'b1, 1'b0);
      if (locked) highs++;
    end
    total++; if (highs != 0) begin bad++; $display("FAIL lockup_locked got=%0d exp=0", highs); end
    gen = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 15) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lockup_early got=%0b exp=0", locked); end
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lockup_relock got=%0b exp=1", locked); end
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    do_reset();
    send_clean(16);
    total++; if (locked_s !== 1'b1) begin bad++; $display("FAIL sat_prelock got=%0b exp=1", locked_s); end
    repeat (20) begin
      send_gen(1'b1, 1'b0);
      if (err_pulse_s) pulses++;
    end
    total++; if (pulses != 20)         begin bad++; $display("FAIL sat_pulses got=%0d exp=20", pulses); end
    total++; if (err_count_s !== 4'd15) begin bad++; $display("FAIL sat_errcnt got=%0d exp=15", err_count_s); end
    total++; if (locked_s !== 1'b1)    begin bad++; $display("FAIL sat_locked got=%0b exp=1", locked_s); end
    send_gen(1'b1, 1'b1);
    total++; if (err_count_s !== 4'd0) begin bad++; $display("FAIL sat_clr got=%0d exp=0", err_count_s); end
    total++; if (err_pulse_s !== 1'b1) begin bad++; $display("FAIL sat_clr_pulse got=%0b exp=1", err_pulse_s); end
    total++; if (err_count !== 16'd0)  begin bad++; $display("FAIL sat_clr_main got=%0d exp=0", err_count); end
    send_gen(1'b1, 1'b0);
    total++; if (err_count_s !== 4'd1) begin bad++; $display("FAIL sat_after_clr got=%0d exp=1", err_count_s); end
  endtask

  task automatic test_gaps();
    gap_en = 1'b1;
    test_clean_lock("gap_lock");
    test_loss_of_lock("gap_loss");
    gap_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_clean(16);
    send_gen(1'b1, 1'b0);
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL rstmid_pre got=%0d exp=1", err_count); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (locked !== 1'b0)     begin bad++; $display("FAIL rstmid_locked got=%0b exp=0", locked); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rstmid_errcnt got=%0d exp=0", err_count); end
    total++; if (err_pulse !== 1'b0)  begin bad++; $display("FAIL rstmid_pulse got=%0b exp=0", err_pulse); end
    @(negedge clk);
    rst_n = 1'b1;
    gen   = 8'h00;
    send_clean(16);
    total++; if (locked !== 1'b1)     begin bad++; $display("FAIL rstmid_relock got=%0b exp=1", locked); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rstmid_errcnt_end got=%0d exp=0", err_count); end
  endtask

  initial begin
    test_reset();
    test_clean_lock("clean");
    test_single_error();
    test_loss_of_lock("loss");
    test_window_boundary();
    test_lockup_seed();
    test_saturation();
    test_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
